// File: rtl/rv_imm_pkg.sv
// Shared immediate-format codes and the RV immediate decode function.
// Used by the pipelined extender and by any model that needs the same decode.
package rv_imm_pkg;

    localparam logic [2:0] IMM_I   = 3'b000;
    localparam logic [2:0] IMM_S   = 3'b001;
    localparam logic [2:0] IMM_B   = 3'b010;
    localparam logic [2:0] IMM_J   = 3'b011;
    localparam logic [2:0] IMM_U   = 3'b100;
    localparam logic [2:0] IMM_Z   = 3'b101;
    localparam logic [2:0] IMM_SH  = 3'b110;
    localparam logic [2:0] IMM_RSV = 3'b111;

    // Decoded result: always 64 bits wide, callers keep the low XLEN bits.
    typedef struct packed {
        logic        err;
        logic [63:0] imm;
    } imm_res_t;

    // instr holds ISA bits [31:7], so ISA bit b lives at instr[b-7].
    function automatic imm_res_t imm_decode(input logic [24:0] instr,
                                            input logic [2:0]  immsrc,
                                            input int          xlen);
        imm_res_t r;
        logic     s;
        s     = instr[24];
        r.err = 1'b0;
        r.imm = '0;
        case (immsrc)
            IMM_I:   r.imm = {{52{s}}, instr[24:13]};
            IMM_S:   r.imm = {{52{s}}, instr[24:18], instr[4:0]};
            IMM_B:   r.imm = {{52{s}}, instr[0], instr[23:18], instr[4:1], 1'b0};
            IMM_J:   r.imm = {{44{s}}, instr[12:5], instr[13], instr[23:14], 1'b0};
            IMM_U:   r.imm = {{32{s}}, instr[24:5], 12'b0};
            IMM_Z:   r.imm = {59'b0, instr[12:8]};
            IMM_SH:  r.imm = (xlen == 64) ? {58'b0, instr[18:13]} : {59'b0, instr[17:13]};
            default: r.err = 1'b1;   // reserved code: zero immediate, flag it
        endcase
        return r;
    endfunction

endpackage

// File: rtl/rv_skid_buf.sv
// Generic 2-entry valid/ready skid buffer: a main output register plus one
// skid register, strict FIFO order, in_ready driven straight from a flop.
//
// Handshake: a beat transfers on a side when valid && ready are both high at
// the rising edge. The source holds valid and data stable until accepted;
// this block holds out_valid/out_data stable while out_valid && !out_ready.
module rv_skid_buf #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    logic         main_valid;
    logic [W-1:0] main_data;
    logic         skid_valid;
    logic [W-1:0] skid_data;
    logic         in_fire;
    logic         main_free;

    // Ready only depends on skid occupancy, never on out_ready this cycle.
    assign in_ready  = !skid_valid;
    assign in_fire   = in_valid && !skid_valid;
    assign main_free = !main_valid || out_ready;
    assign out_valid = main_valid;
    assign out_data  = main_data;

    // Main reloads from skid first (older entry), else from the input; the
    // skid only captures when the main register is stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_valid <= 1'b0;
            main_data  <= '0;
            skid_valid <= 1'b0;
            skid_data  <= '0;
        end else if (main_free) begin
            main_valid <= skid_valid || in_fire;
            if (skid_valid) begin
                main_data  <= skid_data;
                skid_valid <= 1'b0;
            end else if (in_fire) begin
                main_data <= in_data;
            end
        end else if (in_fire) begin
            skid_valid <= 1'b1;
            skid_data  <= in_data;
        end
    end

endmodule

// File: rtl/imm_gen_pipe.sv
// Pipelined RV immediate extender: combinational decode into a 2-entry skid
// buffer, one cycle latency, full throughput, reserved selectors flagged.
module imm_gen_pipe
    import rv_imm_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [24:0]      instr,
    input  logic [2:0]       immsrc,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  immext,
    output logic [TAG_W-1:0] out_tag,
    output logic             imm_err
);

    localparam int W = XLEN + TAG_W + 1;

    generate
        if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
            $error("imm_gen_pipe: XLEN must be 32 or 64");
        end
    endgenerate

    imm_res_t     dec;
    logic [W-1:0] in_data;
    logic [W-1:0] out_data;

    // Decode ahead of the registers so stored entries are final results.
    always_comb begin
        dec = imm_decode(instr, immsrc, XLEN);
    end

    generate
        if (XLEN < 64) begin : g_trim
            // Upper decode bits are only sign copies when XLEN is 32.
            logic unused_hi;
            assign unused_hi = ^dec.imm[63:XLEN];
        end
    endgenerate

    assign in_data = {dec.err, in_tag, dec.imm[XLEN-1:0]};
    assign {imm_err, out_tag, immext} = out_data;

    rv_skid_buf #(.W(W)) u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed bench for imm_gen_pipe: one XLEN=32 and one XLEN=64 instance fed
// the same stream, hand-computed expected values.
module tb_imm_gen_pipe;
    import rv_imm_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        in_valid;
    logic [24:0] instr;
    logic [2:0]  immsrc;
    logic [4:0]  in_tag;
    logic        out_ready;

    logic        in_ready32, out_valid32, err32;
    logic [31:0] imm32;
    logic [4:0]  tag32;
    logic        in_ready64, out_valid64, err64;
    logic [63:0] imm64;
    logic [4:0]  tag64;

    imm_gen_pipe #(.XLEN(32), .TAG_W(5)) dut32 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready32),
        .instr(instr), .immsrc(immsrc), .in_tag(in_tag), .out_valid(out_valid32),
        .out_ready(out_ready), .immext(imm32), .out_tag(tag32), .imm_err(err32)
    );

    imm_gen_pipe #(.XLEN(64), .TAG_W(5)) dut64 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready64),
        .instr(instr), .immsrc(immsrc), .in_tag(in_tag), .out_valid(out_valid64),
        .out_ready(out_ready), .immext(imm64), .out_tag(tag64), .imm_err(err64)
    );

    // ---------------- scoreboard ----------------
    int n_tests = 0;
    int n_fail  = 0;
    logic [68:0] exp_q[$];   // {tag, imm64}

    task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, obs, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic xfer(input logic [24:0] i, input logic [2:0] s, input logic [4:0] t);
        instr    = i;
        immsrc   = s;
        in_tag   = t;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic check_out(input string name, input logic [31:0] e32, input logic [63:0] e64,
                             input logic e_err, input logic [4:0] e_tag);
        check({name, "_v32"},   64'(out_valid32), 64'd1);
        check({name, "_v64"},   64'(out_valid64), 64'd1);
        check({name, "_imm32"}, 64'(imm32), 64'(e32));
        check({name, "_imm64"}, imm64, e64);
        check({name, "_err32"}, 64'(err32), 64'(e_err));
        check({name, "_err64"}, 64'(err64), 64'(e_err));
        check({name, "_tag32"}, 64'(tag32), 64'(e_tag));
        check({name, "_tag64"}, 64'(tag64), 64'(e_tag));
    endtask

    task automatic check_idle(input string name);
        check({name, "_v32"},   64'(out_valid32), 64'd0);
        check({name, "_v64"},   64'(out_valid64), 64'd0);
        check({name, "_imm32"}, 64'(imm32), 64'd0);
        check({name, "_imm64"}, imm64, 64'd0);
        check({name, "_tag64"}, 64'(tag64), 64'd0);
        check({name, "_err64"}, 64'(err64), 64'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        int          sent;
        int          got;
        logic        hold;
        logic [4:0]  prev_tag;
        logic [63:0] prev_imm;
        logic [68:0] e;

        rst_n = 1'b0; in_valid = 1'b0; instr = '0; immsrc = '0; in_tag = '0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_idle("reset");
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("rst_rdy32", 64'(in_ready32), 64'd1);
        check("rst_rdy64", 64'(in_ready64), 64'd1);

        // Formats, back-to-back with out_ready high
        xfer(25'h1FFE000, IMM_I, 5'd1);
        check_out("i_fff", 32'hFFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 5'd1);
        xfer(25'h1FC001E, IMM_S, 5'd2);
        check_out("s_m2", 32'hFFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 5'd2);
        xfer(25'h1000000, IMM_B, 5'd3);
        check_out("b_m4096", 32'hFFFF_F000, 64'hFFFF_FFFF_FFFF_F000, 1'b0, 5'd3);
        xfer(25'h0004000, IMM_J, 5'd4);
        check_out("j_p2", 32'h2, 64'h2, 1'b0, 5'd4);
        xfer(25'h1000000, IMM_U, 5'd5);
        check_out("u_8", 32'h8000_0000, 64'hFFFF_FFFF_8000_0000, 1'b0, 5'd5);
        xfer(25'h1001F00, IMM_Z, 5'd6);
        check_out("z_1f", 32'h1F, 64'h1F, 1'b0, 5'd6);
        xfer(25'h007E000, IMM_SH, 5'd7);
        check_out("sh_3f", 32'h1F, 64'h3F, 1'b0, 5'd7);
        xfer(25'h1FFFFFF, IMM_RSV, 5'd8);
        check_out("rsv", 32'h0, 64'h0, 1'b1, 5'd8);
        xfer(25'h0000000, IMM_I, 5'd9);
        check_out("after_rsv", 32'h0, 64'h0, 1'b0, 5'd9);
        @(posedge clk);
        #1;
        check("drain_v32", 64'(out_valid32), 64'd0);
        check("drain_v64", 64'(out_valid64), 64'd0);

        // Backpressure: out_ready low for the first 3 cycles of a 4-txn stream
        sent = 0; got = 0; hold = 1'b0; prev_tag = '0; prev_imm = '0;
        for (int c = 0; c < 30 && got < 4; c++) begin
            out_ready = (c >= 3);
            if (sent < 4) begin
                instr    = {12'(sent + 1), 13'b0};
                immsrc   = IMM_I;
                in_tag   = 5'(sent + 1);
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            if (c == 2) begin
                check("bp_rdy_low32", 64'(in_ready32), 64'd0);
                check("bp_rdy_low64", 64'(in_ready64), 64'd0);
            end
            if (hold) begin
                check("bp_hold_tag", 64'(tag64), 64'(prev_tag));
                check("bp_hold_imm", imm64, prev_imm);
            end
            if (out_valid64 && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("bp_unexpected", 64'd1, 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("bp_tag64", 64'(tag64), 64'(e[68:64]));
                    check("bp_imm64", imm64, e[63:0]);
                    check("bp_tag32", 64'(tag32), 64'(e[68:64]));
                    check("bp_imm32", 64'(imm32), 64'(e[31:0]));
                end
                got++;
            end
            hold     = out_valid64 && !out_ready;
            prev_tag = tag64;
            prev_imm = imm64;
            if (in_valid && in_ready64) begin
                exp_q.push_back({5'(sent + 1), 64'(sent + 1)});
                sent++;
            end
            @(posedge clk);
            #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check("bp_got", 64'(got), 64'd4);
        check("bp_q_empty", 64'(exp_q.size()), 64'd0);

        // Reset with main and skid both full
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        xfer({12'd10, 13'b0}, IMM_I, 5'd10);
        xfer({12'd11, 13'b0}, IMM_I, 5'd11);
        check("full_rdy64", 64'(in_ready64), 64'd0);
        check("full_v64", 64'(out_valid64), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_idle("async_rst");
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst_rdy32", 64'(in_ready32), 64'd1);
        check("post_rst_rdy64", 64'(in_ready64), 64'd1);
        for (int k = 0; k < 3; k++) begin
            check("no_stale_v32", 64'(out_valid32), 64'd0);
            check("no_stale_v64", 64'(out_valid64), 64'd0);
            @(posedge clk);
            #1;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
